boot_loader: RTL

Program loader upstream of the 16-bit CPU core. It accepts a byte-serial program frame over a valid/ready stream and assembles bytes into 16-bit instruction words. It writes each word into instruction memory and holds the CPU in reset until the frame is complete and verified. On success it releases the CPU, which then fetches from address 0.

---
 rtl/boot_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-serial program loader: assembles 16-bit words into instruction memory and
// holds the CPU in reset until the frame is complete. Option: BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, HI, LO, CHK, DONE, ERR} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic              run;
    logic              accept;
    logic              last_word;
    logic [ADDR_W:0]   word_cnt;
    logic [7:0]        hi_byte;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign accept    = in_valid & in_ready;
    assign last_word = (word_cnt == CNT_ONE);
    assign cpu_rst   = ~done;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = HI;
            HI:   if (accept) state_next = LO;
            LO: begin
                if (accept) begin
                    if (!last_word) state_next = HI;
                    else
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK:  if (accept) state_next = (in_data == chk_acc) ? DONE : ERR;
`endif
            default: state_next = state;
        endcase
    end

    // run keeps in_ready low for the first cycle after reset is released
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE, HI, LO: in_ready = run;
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK:          in_ready = run;
`endif
            default:      in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run        <= 1'b0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
        end else begin
            run     <= 1'b1;
            imem_we <= accept && (state == LO);
            // address advances at the end of the write pulse, wrapping after the last word
            if (imem_we) imem_addr <= imem_addr + ADDR_ONE;
            if (accept && (state == IDLE))
                word_cnt <= (in_data == 8'd0) ? CNT_FULL : (ADDR_W+1)'(in_data);
            if (accept && (state == LO)) begin
                word_cnt   <= word_cnt - CNT_ONE;
                imem_wdata <= {hi_byte, in_data};
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            done <= (state_next == DONE);
`else
            // one cycle later so the final write lands before the CPU is released
            done <= (state == DONE);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state == HI)) hi_byte <= in_data;
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_acc <= '0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE)
                chk_acc <= '0;
            else if (accept && ((state == HI) || (state == LO)))
                chk_acc <= chk_acc ^ in_data;
            err <= (state_next == ERR);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
